wb_arbiter_scoreboard: RTL and testbench

Shares the single register-file write port between the ALU and LSU writeback streams, and tracks pending destination registers in a busy-bit scoreboard. Sits between the execute/memory units and the 32x64 register file, and drives its write_en/rd_addr/rd port from a registered output stage. The decode/issue stage queries the scoreboard for source hazards and is back-pressured on destination (WAW) hazards and on the outstanding-operation limit.

---
 rtl/wb_arbiter_scoreboard_pkg.sv | 26 ++
 rtl/wb_arbiter_scoreboard_rr_arbiter2.sv | 55 +++++
 rtl/wb_arbiter_scoreboard.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// wb_arbiter_scoreboard_pkg
// Shared types and constants for the writeback arbiter / busy-bit scoreboard.
//   REG_ADDR_W : register address width
//   XLEN       : register data width
//   NREG       : architectural register count (register 0 reads as zero)
//   unit_sel_e : which writeback unit (ALU or LSU)
//   wb_req_t   : one writeback request {rd, data}
// ----------------------------------------------------------------------------
package wb_arbiter_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 64;
    localparam int NREG       = 32;

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_LSU = 1'b1
    } unit_sel_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_scoreboard_rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with a last-grant pointer. On a tie the unit
// that was not granted last wins; a lone requester is always granted.
//   clk, rst  : clock, asynchronous active-high reset (pointer -> LSU, so the
//               ALU wins the first tie)
//   en        : arbitration enable; when low no grant is issued
//   req_alu   : ALU requests
//   req_lsu   : LSU requests
//   gnt_alu   : ALU granted this cycle
//   gnt_lsu   : LSU granted this cycle
// ----------------------------------------------------------------------------
module rr_arbiter2
    import wb_arbiter_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu
);

    unit_sel_e last_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        if (en) begin
            if (req_alu && req_lsu) begin
                gnt_alu = (last_q == SEL_LSU);
                gnt_lsu = (last_q == SEL_ALU);
            end else begin
                gnt_alu = req_alu;
                gnt_lsu = req_lsu;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= SEL_LSU;
        end else if (gnt_alu) begin
            last_q <= SEL_ALU;
        end else if (gnt_lsu) begin
            last_q <= SEL_LSU;
        end
    end

endmodule

// File: rtl/wb_arbiter_scoreboard.sv
// ----------------------------------------------------------------------------
// wb_arbiter_scoreboard
// Shares the single register-file write port between the ALU and LSU
// writeback streams (round-robin, one grant per cycle, one-cycle registered
// output stage) and tracks pending destination registers in a busy-bit
// scoreboard used by decode for source hazards and WAW back-pressure.
//   clk, rst                 : clock, asynchronous active-high reset
//   flush                    : drop all tracking and the next staged write
//   issue_valid/rd/ready     : decode issue handshake and destination
//   rs1_addr/rs2_addr        : source hazard queries
//   rs1_busy/rs2_busy        : source has a pending write (never for x0)
//   alu_valid/rd/data/ready  : ALU writeback request and grant
//   lsu_valid/rd/data/ready  : LSU writeback request and grant
//   rf_write_en/rd_addr/data : registered register-file write port
//   outstanding              : tracked in-flight write count
//   wb_err                   : sticky, writeback hit a non-busy register
// ----------------------------------------------------------------------------
module wb_arbiter_scoreboard
    import wb_arbiter_scoreboard_pkg::*;
#(
    parameter int XLEN            = wb_arbiter_scoreboard_pkg::XLEN,
    parameter int NREG            = wb_arbiter_scoreboard_pkg::NREG,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]       rf_rd_data,
    output logic [4:0]            outstanding,
    output logic                  wb_err
);

    logic [NREG-1:0]       busy_q, busy_d;
    logic [4:0]            outstanding_q, outstanding_d;
    logic                  wb_err_q, wb_err_d;
    logic                  stage_valid_q;
    logic [REG_ADDR_W-1:0] stage_addr_q;
    logic [XLEN-1:0]       stage_data_q;

    logic                  gnt_alu, gnt_lsu, grant;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  issue_fire;

    // ---------------------------------------------------------------- arbiter
    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (!flush),
        .req_alu (alu_valid),
        .req_lsu (lsu_valid),
        .gnt_alu (gnt_alu),
        .gnt_lsu (gnt_lsu)
    );

    assign alu_ready = gnt_alu;
    assign lsu_ready = gnt_lsu;
    assign grant     = gnt_alu | gnt_lsu;
    assign sel_rd    = gnt_alu ? alu_rd   : lsu_rd;
    assign sel_data  = gnt_alu ? alu_data : lsu_data;

    // -------------------------------------------------------------- queries
    // Reads come straight from registered state: a write staged this cycle is
    // not bypassed, so its register still reads busy until the next cycle.
    assign rs1_busy    = busy_q[rs1_addr] & (rs1_addr != '0);
    assign rs2_busy    = busy_q[rs2_addr] & (rs2_addr != '0);
    assign issue_ready = !flush
                       & ((issue_rd == '0) | !busy_q[issue_rd])
                       & (outstanding_q < 5'(MAX_OUTSTANDING));
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

    // ---------------------------------------------------- scoreboard update
    always_comb begin
        busy_d        = busy_q;
        outstanding_d = outstanding_q;
        wb_err_d      = wb_err_q;

        // Retire the staged write; a write to a non-busy register is still
        // performed but flagged, and the counter is left alone (no underflow).
        if (stage_valid_q) begin
            if (busy_q[stage_addr_q]) begin
                busy_d[stage_addr_q] = 1'b0;
                outstanding_d        = outstanding_d - 5'd1;
            end else begin
                wb_err_d = 1'b1;
            end
        end

        // Applied after the retire so a new pending write on the same register
        // (possible only after an erroneous writeback) stays tracked.
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
            outstanding_d    = outstanding_d + 5'd1;
        end

        if (flush) begin
            busy_d        = '0;
            outstanding_d = '0;
        end
    end

    // NOTE: busy bits are a flop vector, not a RAM, so a full async reset is
    // legal and required: reset must drop every pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            wb_err_q      <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            wb_err_q      <= wb_err_d;
            // Grants are already suppressed during flush; an x0 grant is
            // consumed without producing a write.
            stage_valid_q <= grant && (sel_rd != '0);
            if (grant && (sel_rd != '0)) begin
                stage_addr_q <= sel_rd;
                stage_data_q <= sel_data;
            end
        end
    end

    assign rf_write_en = stage_valid_q;
    assign rf_rd_addr  = stage_addr_q;
    assign rf_rd_data  = stage_data_q;
    assign outstanding = outstanding_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter_scoreboard
// Self-checking bench: directed scenarios followed by random traffic, all
// compared each cycle against a behavioural model of the scoreboard and the
// writeback port kept in plain bit vectors and integers.
// ----------------------------------------------------------------------------
module tb_wb_arbiter_scoreboard;
    import wb_arbiter_scoreboard_pkg::*;

    localparam int MAXO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        lsu_ready;
    logic        rf_write_en;
    logic [4:0]  rf_rd_addr;
    logic [63:0] rf_rd_data;
    logic [4:0]  outstanding;
    logic        wb_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    bit [31:0] m_busy;
    int        m_out;
    bit        m_last_lsu;
    bit        m_err;
    bit        m_stage_v;
    wb_req_t   m_stage;

    always #5 clk = ~clk;

    wb_arbiter_scoreboard #(
        .XLEN            (64),
        .NREG            (32),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .rf_write_en (rf_write_en),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .outstanding (outstanding),
        .wb_err      (wb_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
    endtask

    task automatic model_reset();
        m_busy     = '0;
        m_out      = 0;
        m_last_lsu = 1'b1;
        m_err      = 1'b0;
        m_stage_v  = 1'b0;
        m_stage    = '0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_wen",  64'(rf_write_en), 64'(0));
        check("rst_addr", 64'(rf_rd_addr),  64'(0));
        check("rst_data", rf_rd_data,       64'(0));
        check("rst_out",  64'(outstanding), 64'(0));
        check("rst_err",  64'(wb_err),      64'(0));
        check("rst_rs1",  64'(rs1_busy),    64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: compare all outputs with the model, clock, advance model.
    task automatic tick();
        bit ir, ga, gl;
        #1;
        ir = !flush && (issue_rd == 0 || !m_busy[issue_rd]) && (m_out < MAXO);
        if (flush) begin
            ga = 1'b0;
            gl = 1'b0;
        end else if (alu_valid && lsu_valid) begin
            ga = m_last_lsu;
            gl = !m_last_lsu;
        end else begin
            ga = alu_valid;
            gl = lsu_valid;
        end
        check("issue_ready", 64'(issue_ready), 64'(ir));
        check("alu_ready",   64'(alu_ready),   64'(ga));
        check("lsu_ready",   64'(lsu_ready),   64'(gl));
        check("rs1_busy",    64'(rs1_busy),    64'(rs1_addr != 0 && m_busy[rs1_addr]));
        check("rs2_busy",    64'(rs2_busy),    64'(rs2_addr != 0 && m_busy[rs2_addr]));
        check("rf_write_en", 64'(rf_write_en), 64'(m_stage_v));
        if (m_stage_v) begin
            check("rf_rd_addr", 64'(rf_rd_addr), 64'(m_stage.rd));
            check("rf_rd_data", rf_rd_data,      m_stage.data);
        end
        check("outstanding", 64'(outstanding), 64'(m_out));
        check("wb_err",      64'(wb_err),      64'(m_err));

        @(posedge clk);
        if (m_stage_v) begin
            if (m_busy[m_stage.rd]) begin
                m_busy[m_stage.rd] = 1'b0;
                m_out--;
            end else begin
                m_err = 1'b1;
            end
        end
        if (issue_valid && ir && issue_rd != 0) begin
            m_busy[issue_rd] = 1'b1;
            m_out++;
        end
        m_stage_v = 1'b0;
        if (ga) begin
            m_last_lsu = 1'b0;
            if (alu_rd != 0) begin
                m_stage_v = 1'b1;
                m_stage   = '{rd: alu_rd, data: alu_data};
            end
        end else if (gl) begin
            m_last_lsu = 1'b1;
            if (lsu_rd != 0) begin
                m_stage_v = 1'b1;
                m_stage   = '{rd: lsu_rd, data: lsu_data};
            end
        end
        if (flush) begin
            m_busy = '0;
            m_out  = 0;
        end
        #1;
    endtask

    initial begin
        issue_rd = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        alu_rd   = '0;
        alu_data = '0;
        lsu_rd   = '0;
        lsu_data = '0;
        do_reset();

        // Issue rd=5, ALU writes it back in cycle 3.
        issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
        tick();
        check("t1_busy_c2", 64'(rs1_busy), 64'(1));
        issue_valid = 1'b0;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick();
        alu_valid = 1'b0;
        check("t1_wen",     64'(rf_write_en), 64'(1));
        check("t1_addr",    64'(rf_rd_addr),  64'(5));
        check("t1_data",    rf_rd_data,       64'h1234);
        check("t1_busy_c4", 64'(rs1_busy),    64'(1));
        tick();
        check("t1_busy_c5", 64'(rs1_busy),    64'(0));
        check("t1_out",     64'(outstanding), 64'(0));

        // Both units valid after reset: ALU, LSU, ALU, LSU.
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'hB2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_wen",  64'(rf_write_en), 64'(1));
            check("t2_addr", 64'(rf_rd_addr),  (i % 2 == 0) ? 64'(1) : 64'(2));
        end
        idle();
        tick();

        // WAW: second issue of rd=7 waits until the writeback has retired.
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        check("t3_blocked", 64'(issue_ready), 64'(0));
        tick();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
        tick();
        alu_valid = 1'b0;
        check("t3_staged_blocked", 64'(issue_ready), 64'(0));
        tick();
        check("t3_ready", 64'(issue_ready), 64'(1));
        tick();
        issue_valid = 1'b0;
        check("t3_out", 64'(outstanding), 64'(1));
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
        tick();

        // Outstanding limit.
        do_reset();
        for (int r = 1; r <= 8; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        issue_rd = 5'd9;
        #1;
        check("t4_full",    64'(outstanding), 64'(8));
        check("t4_blocked", 64'(issue_ready), 64'(0));
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 64'h11;
        tick();
        lsu_valid = 1'b0;
        tick();
        check("t4_ready", 64'(issue_ready), 64'(1));
        tick();
        issue_valid = 1'b0;
        check("t4_out", 64'(outstanding), 64'(8));

        // LSU write to x0 is consumed without a register-file write.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hFFFF; rs1_addr = 5'd0;
        #1;
        check("t5_ready", 64'(lsu_ready), 64'(1));
        tick();
        lsu_valid = 1'b0;
        check("t5_wen", 64'(rf_write_en), 64'(0));
        check("t5_out", 64'(outstanding), 64'(8));
        check("t5_rs1", 64'(rs1_busy),    64'(0));
        tick();

        // Flush after a grant, then a writeback to a non-busy register.
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
        tick();
        alu_valid = 1'b0;
        flush = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd6;
        tick();
        idle();
        check("t6_wen",  64'(rf_write_en), 64'(0));
        check("t6_out",  64'(outstanding), 64'(0));
        check("t6_busy", 64'(rs1_busy),    64'(0));
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h44;
        tick();
        lsu_valid = 1'b0;
        tick();
        check("t6_err", 64'(wb_err), 64'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_err_sticky", 64'(wb_err), 64'(1));
        end
        do_reset();

        // Random traffic with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
            end
            flush       = ($urandom_range(0, 24) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 9));
            rs1_addr    = 5'($urandom_range(0, 9));
            rs2_addr    = 5'($urandom_range(0, 9));
            alu_valid   = 1'($urandom_range(0, 1));
            alu_rd      = 5'($urandom_range(0, 9));
            alu_data    = {$urandom(), $urandom()};
            lsu_valid   = 1'($urandom_range(0, 1));
            lsu_rd      = 5'($urandom_range(0, 9));
            lsu_data    = {$urandom(), $urandom()};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
